// File: rtl/mux_scan_n_pkg.sv
// mux_scan_pkg: shared constants and types for the mux_scan_n slice.
//   MODE_MANUAL / MODE_SCAN : values of the mode input
//   out_state_e             : output-stage state (ST_EMPTY / ST_FULL)
//   wrap_add()              : modular index addition used for the rotating pointer
package mux_scan_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

    // (a + b) mod n, for channel indices that need not wrap at a power of 2.
    function automatic int unsigned wrap_add(int unsigned a, int unsigned b, int unsigned n);
        return (a + b) % n;
    endfunction

endpackage

// File: rtl/mux_scan_n_if.sv
// mux_scan_n_if: handshake/data bundle between the sources, the mux and the consumer.
//   mode, sel           : select mode and manual channel index
//   d, in_valid         : packed channel data and per-channel valid
//   in_ready            : one-hot grant back to the sources
//   out_ready           : consumer accepts y
//   y, y_valid, y_chan  : registered output word, its valid and its source channel
//   y_par               : even parity of y (0 when parity is not built)
// master = the environment (sources + consumer), slave = the mux.
interface mux_scan_n_if #(
    parameter int unsigned WIDTH    = 2,
    parameter int unsigned CHANNELS = 4
);
    localparam int unsigned SEL_W = $clog2(CHANNELS);

    logic                      mode;
    logic [SEL_W-1:0]          sel;
    logic [CHANNELS*WIDTH-1:0] d;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic                      out_ready;
    logic [WIDTH-1:0]          y;
    logic                      y_valid;
    logic [SEL_W-1:0]          y_chan;
    logic                      y_par;

    modport master (
        output mode, sel, d, in_valid, out_ready,
        input  in_ready, y, y_valid, y_chan, y_par
    );

    modport slave (
        input  mode, sel, d, in_valid, out_ready,
        output in_ready, y, y_valid, y_chan, y_par
    );

endinterface

// File: rtl/mux_scan_n_rr_pick.sv
// rr_pick: combinational rotating-priority search.
//   in_valid : per-channel request
//   ptr      : channel with highest priority; search goes upward and wraps
//   found    : some channel is requesting
//   idx      : first requesting channel at or after ptr
module rr_pick
    import mux_scan_pkg::*;
#(
    parameter int unsigned CHANNELS = 4
) (
    input  logic [CHANNELS-1:0]         in_valid,
    input  logic [$clog2(CHANNELS)-1:0] ptr,
    output logic                        found,
    output logic [$clog2(CHANNELS)-1:0] idx
);
    localparam int unsigned SEL_W = $clog2(CHANNELS);

    logic [SEL_W-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest hit is the one left standing.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = int'(CHANNELS) - 1; i >= 0; i--) begin
            cand = SEL_W'(wrap_add(32'(ptr), 32'(i), CHANNELS));
            if (in_valid[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux_scan_n.sv
// mux_scan_n: registered N-channel, W-bit multiplexer with valid/ready handshakes.
//   clk, reset : clock and synchronous active-high reset
//   bus        : mux_scan_n_if.slave (mode, sel, d, in_valid, in_ready, out_ready,
//                y, y_valid, y_chan, y_par)
// Manual mode grants channel sel; scan mode grants round-robin from ptr over valid channels.
// One output register stage; in_ready is the combinational one-hot grant.
// Optional feature macro MUX_SCAN_PARITY_EN: registers even parity of y on y_par;
// without it y_par is tied to 0.
module mux_scan_n
    import mux_scan_pkg::*;
#(
    parameter int unsigned WIDTH    = 2,
    parameter int unsigned CHANNELS = 4
) (
    input logic         clk,
    input logic         reset,
    mux_scan_n_if.slave bus
);
    localparam int unsigned SEL_W = $clog2(CHANNELS);

    out_state_e       st_q;
    logic [SEL_W-1:0] ptr_q;
    logic [WIDTH-1:0] y_q;
    logic [SEL_W-1:0] y_chan_q;

    logic             scan_found;
    logic [SEL_W-1:0] scan_idx;
    logic             man_found;
    logic             grant_found;
    logic [SEL_W-1:0] grant_idx;
    logic             load;
    logic [WIDTH-1:0] grant_data;

    rr_pick #(
        .CHANNELS (CHANNELS)
    ) u_rr_pick (
        .in_valid (bus.in_valid),
        .ptr      (ptr_q),
        .found    (scan_found),
        .idx      (scan_idx)
    );

    // Out-of-range sel (possible when CHANNELS is not a power of 2) never grants.
    assign man_found   = (32'(bus.sel) < CHANNELS) && bus.in_valid[bus.sel];
    assign grant_found = (bus.mode == MODE_SCAN) ? scan_found : man_found;
    assign grant_idx   = (bus.mode == MODE_SCAN) ? scan_idx : bus.sel;
    assign load        = ((st_q == ST_EMPTY) || bus.out_ready) && grant_found && !reset;
    assign grant_data  = bus.d[grant_idx*WIDTH +: WIDTH];

    assign bus.in_ready = load ? (CHANNELS'(1) << grant_idx) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q     <= ST_EMPTY;
            ptr_q    <= '0;
            y_q      <= '0;
            y_chan_q <= '0;
        end else begin
            unique case (st_q)
                ST_EMPTY: if (load) st_q <= ST_FULL;
                ST_FULL:  if (bus.out_ready && !load) st_q <= ST_EMPTY;
            endcase
            if (load) begin
                y_q      <= grant_data;
                y_chan_q <= grant_idx;
                // The scan pointer is frozen while in manual mode.
                if (bus.mode == MODE_SCAN) begin
                    ptr_q <= SEL_W'(wrap_add(32'(grant_idx), 32'd1, CHANNELS));
                end
            end
        end
    end

`ifdef MUX_SCAN_PARITY_EN
    logic y_par_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            y_par_q <= 1'b0;
        end else if (load) begin
            y_par_q <= ^grant_data;
        end
    end

    assign bus.y_par = y_par_q;
`else
    assign bus.y_par = 1'b0;
`endif

    assign bus.y       = y_q;
    assign bus.y_valid = (st_q == ST_FULL);
    assign bus.y_chan  = y_chan_q;

endmodule

// File: tb/tb_mux_scan_n.sv
// Self-checking bench for mux_scan_n (WIDTH=2, CHANNELS=4): directed vectors with
// literal expectations, plus a per-cycle comparison against a behavioural model.
module tb_mux_scan_n;
    localparam int unsigned W = 2;
    localparam int unsigned C = 4;

    logic clk = 1'b0;
    logic reset;
    logic cmp_en = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    mux_scan_n_if #(.WIDTH(W), .CHANNELS(C)) bus ();

    mux_scan_n #(
        .WIDTH    (W),
        .CHANNELS (C)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: what the consumer should see, from the handshake rules.
    logic [1:0]  m_y;
    logic        m_valid;
    logic [1:0]  m_chan;
    logic        m_par;
    int unsigned m_ptr;
    logic        e_found;
    int unsigned e_idx;
    int unsigned e_c;
    logic        e_load;
    logic [3:0]  e_in_ready;
    logic [1:0]  e_data;

    always_comb begin
        e_found = 1'b0;
        e_idx   = 0;
        e_c     = 0;
        if (bus.mode == 1'b0) begin
            e_idx   = 32'(bus.sel);
            e_found = (e_idx < C) && bus.in_valid[bus.sel];
        end else begin
            for (int off = 0; off < int'(C); off++) begin
                e_c = (m_ptr + 32'(off)) % C;
                if (!e_found && bus.in_valid[e_c[1:0]]) begin
                    e_found = 1'b1;
                    e_idx   = e_c;
                end
            end
        end
        e_load     = (!m_valid || bus.out_ready) && e_found && !reset;
        e_in_ready = e_load ? 4'(1 << e_idx) : 4'b0000;
        e_data     = bus.d[e_idx*W +: W];
    end

    always @(posedge clk) begin
        if (reset) begin
            m_valid <= 1'b0;
            m_y     <= 2'b00;
            m_chan  <= 2'd0;
            m_par   <= 1'b0;
            m_ptr   <= 0;
        end else if (e_load) begin
            m_valid <= 1'b1;
            m_y     <= e_data;
            m_chan  <= e_idx[1:0];
`ifdef MUX_SCAN_PARITY_EN
            m_par   <= e_data[0] ^ e_data[1];
`else
            m_par   <= 1'b0;
`endif
            if (bus.mode) m_ptr <= (e_idx + 1) % C;
        end else if (bus.out_ready) begin
            m_valid <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_in_ready", 32'(bus.in_ready), 32'(e_in_ready));
            chk("cyc_y_valid", 32'(bus.y_valid), 32'(m_valid));
            chk("cyc_y", 32'(bus.y), 32'(m_y));
            chk("cyc_y_chan", 32'(bus.y_chan), 32'(m_chan));
            chk("cyc_y_par", 32'(bus.y_par), 32'(m_par));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset         = 1'b1;
        bus.mode      = 1'b1;
        bus.sel       = 2'd0;
        bus.d         = 8'b11_10_01_00;
        bus.in_valid  = 4'b1111;
        bus.out_ready = 1'b1;

        // Reset held two cycles with every channel valid.
        tick();
        cmp_en = 1'b1;
        #2;
        chk("rst_in_ready", 32'(bus.in_ready), 32'h0);
        chk("rst_y", 32'(bus.y), 32'h0);
        chk("rst_y_valid", 32'(bus.y_valid), 32'h0);
        chk("rst_y_chan", 32'(bus.y_chan), 32'h0);
        tick();
        #2;
        chk("rst2_in_ready", 32'(bus.in_ready), 32'h0);
        reset = 1'b0;
        #1;
        chk("first_grant", 32'(bus.in_ready), 32'h1);

        // Scan at full rate: channels 0,1,2,3,0 with data equal to index.
        for (int k = 0; k < 5; k++) begin
            tick();
            #2;
            chk("scan_y_chan", 32'(bus.y_chan), 32'(k % 4));
            chk("scan_y", 32'(bus.y), 32'(k % 4));
            chk("scan_y_valid", 32'(bus.y_valid), 32'h1);
            chk("scan_in_ready", 32'(bus.in_ready), 32'(1 << ((k + 1) % 4)));
            if (k == 3) begin
`ifdef MUX_SCAN_PARITY_EN
                chk("par_y11", 32'(bus.y_par), 32'h0);
`else
                chk("par_off_y11", 32'(bus.y_par), 32'h0);
`endif
            end
        end

        // Manual: sel=2 with only ch2 valid; mode change acts on the same cycle.
        bus.mode     = 1'b0;
        bus.sel      = 2'd2;
        bus.in_valid = 4'b0100;
        #1;
        chk("man_in_ready", 32'(bus.in_ready), 32'h4);
        tick();
        #2;
        chk("man_y", 32'(bus.y), 32'h2);
        chk("man_y_valid", 32'(bus.y_valid), 32'h1);
        chk("man_y_chan", 32'(bus.y_chan), 32'h2);
        bus.sel      = 2'd1;
        bus.in_valid = 4'b0000;
        #1;
        chk("man_nogrant", 32'(bus.in_ready), 32'h0);
        tick();
        #2;
        chk("man_drain", 32'(bus.y_valid), 32'h0);

        // Scan wrap: ptr is 1 (kept through manual mode), ch3 then ch0.
        bus.mode     = 1'b1;
        bus.in_valid = 4'b1001;
        #1;
        chk("wrap_in_ready3", 32'(bus.in_ready), 32'h8);
        tick();
        #2;
        chk("wrap_y_chan3", 32'(bus.y_chan), 32'h3);
        chk("wrap_in_ready0", 32'(bus.in_ready), 32'h1);
        tick();
        #2;
        chk("wrap_y_chan0", 32'(bus.y_chan), 32'h0);
        chk("wrap_y0", 32'(bus.y), 32'h0);

        // Backpressure: fill with y=01 from ch1, then stall three cycles.
        bus.mode     = 1'b0;
        bus.sel      = 2'd1;
        bus.in_valid = 4'b0010;
        tick();
        #2;
        chk("bp_fill_y", 32'(bus.y), 32'h1);
`ifdef MUX_SCAN_PARITY_EN
        chk("par_y01", 32'(bus.y_par), 32'h1);
`else
        chk("par_off_y01", 32'(bus.y_par), 32'h0);
`endif
        bus.out_ready = 1'b0;
        #1;
        chk("bp_in_ready", 32'(bus.in_ready), 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            #2;
            chk("bp_y", 32'(bus.y), 32'h1);
            chk("bp_y_chan", 32'(bus.y_chan), 32'h1);
            chk("bp_y_valid", 32'(bus.y_valid), 32'h1);
            chk("bp_stall", 32'(bus.in_ready), 32'h0);
        end
        bus.out_ready = 1'b1;
        bus.sel       = 2'd2;
        bus.in_valid  = 4'b0100;
        #1;
        chk("bp_release_grant", 32'(bus.in_ready), 32'h4);
        tick();
        #2;
        chk("bp_replace_y", 32'(bus.y), 32'h2);
        chk("bp_replace_valid", 32'(bus.y_valid), 32'h1);

        // Reset while FULL and stalled discards the word and clears ptr.
        bus.out_ready = 1'b0;
        bus.mode      = 1'b1;
        bus.in_valid  = 4'b1111;
        reset         = 1'b1;
        #1;
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'h0);
        tick();
        #2;
        chk("mid_rst_valid", 32'(bus.y_valid), 32'h0);
        chk("mid_rst_y", 32'(bus.y), 32'h0);
        reset         = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        chk("mid_rst_ptr", 32'(bus.in_ready), 32'h1);
        for (int k = 0; k < 4; k++) tick();
        bus.in_valid = 4'b0000;
        tick();
        tick();
        #2;
        cmp_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mux_scan_n.md
# mux_scan_n

Registered, parametrised N-channel, W-bit multiplexer with handshakes. It generalises the 2:1 single-bit muxes to CHANNELS inputs of WIDTH bits, each with a valid/ready handshake. It has two select modes: manual, where `sel` picks the channel, and scan, a round-robin over the valid channels. The result is one registered output stage with valid/ready. It sits between several lab data sources and a single consumer (display/LED driver, or downstream datapath).

## Interface
- `WIDTH`, default 2: data bits per channel.
- `CHANNELS`, default 4: number of inputs, ≥2; need not be a power of 2.
- `SEL_W`, default `$clog2(CHANNELS)`: select/channel-index width; derived, not overridden.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high.
- `mode`, input, 1: 0 = manual, 1 = scan.
- `sel`, input, SEL_W: channel index used in manual mode.
- `d`, input, CHANNELS*WIDTH: packed inputs; channel k is `d[k*WIDTH +: WIDTH]`.
- `in_valid`, input, CHANNELS: per-channel data valid.
- `in_ready`, output, CHANNELS: one-hot grant; channel k's data is taken this cycle. Combinational.
- `out_ready`, input, 1: consumer accepts `y` this cycle.
- `y`, output, WIDTH: registered selected data.
- `y_valid`, output, 1: `y` holds unconsumed data.
- `y_chan`, output, SEL_W: index of the channel that produced `y`.
- `y_par`, output, 1: even parity of `y`. See Configuration.

## Operation
- Output stage states:
  - EMPTY: `y_valid`=0.
  - FULL: `y_valid`=1.
- `load` = (EMPTY or `out_ready`) and a grant exists and not `reset`.
- Transitions:
  - EMPTY → FULL on `load`.
  - FULL → FULL on `out_ready` & `load`.
  - FULL → EMPTY on `out_ready` & !`load`.
  - FULL holds while !`out_ready`.
- Grant in manual mode:
  - Grant channel `sel` if `sel` < CHANNELS and `in_valid[sel]`.
  - `sel` ≥ CHANNELS means no grant.
- Grant in scan mode:
  - Search begins at pointer `ptr` and goes upward, wrapping CHANNELS-1 → 0.
  - The first channel with `in_valid` set is granted.
  - On `load`, `ptr` ← (granted + 1) mod CHANNELS. Otherwise `ptr` holds.
- Mode switching:
  - `ptr` is kept in manual mode and is not updated there.
  - A mode change takes effect on the same-cycle grant decision.
- `in_ready` = one-hot(granted) when `load`, else all zeros.
- On `load`:
  - `y` ← granted channel data.
  - `y_chan` ← granted index.
  - `y_valid` ← 1.
- Transfers and stalls:
  - An upstream transfer occurs when `in_valid[k]` & `in_ready[k]`.
  - A non-granted valid channel stalls; it must hold its data.
- Reset values:
  - `y`=0, `y_valid`=0, `y_chan`=0, `y_par`=0, `ptr`=0.
  - `in_ready`=0 throughout any cycle with `reset` high.
- Reset mid-operation discards held data: FULL → EMPTY at the next edge, with no `out_ready` needed.

## Timing
- Latency:
  - Data granted in cycle n appears on `y` with `y_valid`=1 from cycle n+1.
  - One register stage only.
- Throughput: one word per cycle while `out_ready`=1, with no bubbles.
- No combinational path from `out_ready` to `y`/`y_valid`.
- `in_ready` depends combinationally on `out_ready`, `y_valid`, `mode`, `sel`, `in_valid`, `ptr`.
- Simultaneous consume and load in FULL: `y` is replaced the same edge and `y_valid` stays 1.
- CHANNELS not a power of 2: `ptr` never takes values ≥ CHANNELS.

## Configuration
- `MUX_SCAN_PARITY_EN` defined:
  - `y_par` registered on `load` as XOR of the granted data (even parity: `y`,`y_par` has even ones count).
  - `y_par` resets to 0.
- `MUX_SCAN_PARITY_EN` not defined:
  - `y_par` tied to 0 and no parity logic is generated.
  - The port list is unchanged.

## Structure
- Package `mux_scan_pkg`:
  - Mode constants `MODE_MANUAL`=1'b0 and `MODE_SCAN`=1'b1.
  - Output-state encoding `ST_EMPTY`/`ST_FULL`.
- Sub-module `rr_pick`, combinational:
  - Inputs: `in_valid`, `ptr`.
  - Outputs: `found`, `idx`.
  - Rotating priority search, parametrised on CHANNELS.
- Top holds `ptr`, the output register, the manual-path select and the grant decode.

## Test plan
All scenarios use WIDTH=2, CHANNELS=4.
- Reset:
  - Stimulus: `reset`=1 for 2 cycles with `in_valid`=1111, `out_ready`=1.
  - Required: `in_ready`=0000, `y`=00, `y_valid`=0, `y_chan`=0.
  - Required: after release, first grant is ch0.
- Manual:
  - Stimulus: `mode`=0, `sel`=2, ch2=10, `in_valid`=0100, `out_ready`=1.
  - Required: `in_ready`=0100 that cycle; next cycle `y`=10, `y_valid`=1, `y_chan`=2.
  - Stimulus: `sel`=1 with `in_valid[1]`=0.
  - Required: `in_ready`=0000 and `y_valid`→0 after consumption.
- Scan, full rate:
  - Stimulus: `mode`=1, ch0..3 = 00,01,10,11, `in_valid`=1111, `out_ready`=1.
  - Required: `y_chan` 0,1,2,3,0 on consecutive cycles, `y` matching each channel.
- Scan wrap, sparse:
  - Stimulus: `ptr`=1, `in_valid`=1001.
  - Required: grants ch3 then ch0, with `in_ready` 1000 then 0001.
- Backpressure:
  - Stimulus: FULL with `y`=01, `out_ready`=0 for 3 cycles.
  - Required: `in_ready`=0000, `y`/`y_chan` stable.
  - Stimulus: `out_ready`=1.
  - Required: next grant loads the same edge and `y_valid` stays 1.
- Parity (macro defined):
  - Required: `y`=11 gives `y_par`=0; `y`=01 gives `y_par`=1.
  - Macro undefined: `y_par`=0 always.
